// File: rtl/latch_write_ctrl.sv
// Write sequencer for transparent D/enable latches: SETUP -> OPEN -> HOLD around a captured din.
// Optional LATCH_WRITE_CTRL_READBACK_EN adds lat_q readback and a wr_err pulse alongside done.
module latch_write_ctrl #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned SETUP_CYC = 1,
   parameter int unsigned OPEN_CYC  = 2,
   parameter int unsigned HOLD_CYC  = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic [DATA_W-1:0] req_data,
   output logic              req_ready,
   output logic [DATA_W-1:0] lat_din,
   output logic              lat_en,
   output logic              busy,
`ifdef LATCH_WRITE_CTRL_READBACK_EN
   input  logic [DATA_W-1:0] lat_q,
   output logic              wr_err,
`endif
   output logic              done
);

   localparam int unsigned MAX_SO  = (SETUP_CYC > OPEN_CYC) ? SETUP_CYC : OPEN_CYC;
   localparam int unsigned MAX_CYC = (MAX_SO > HOLD_CYC) ? MAX_SO : HOLD_CYC;
   localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

   // Counters load len-1 on state entry and the state exits when they reach zero
   localparam logic [CNT_W-1:0] SETUP_LD = (SETUP_CYC != 0) ? CNT_W'(SETUP_CYC - 1) : '0;
   localparam logic [CNT_W-1:0] OPEN_LD  = (OPEN_CYC  != 0) ? CNT_W'(OPEN_CYC - 1)  : '0;
   localparam logic [CNT_W-1:0] HOLD_LD  = (HOLD_CYC  != 0) ? CNT_W'(HOLD_CYC - 1)  : '0;

   if (OPEN_CYC < 1) begin : g_open_check
      $error("latch_write_ctrl: OPEN_CYC must be >= 1");
   end

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_OPEN, S_HOLD} state_t;

   state_t            state, state_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic [DATA_W-1:0] din_n;
   logic              en_n, busy_n, ready_n, done_n;

   // State and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         lat_din   <= '0;
         lat_en    <= 1'b0;
         busy      <= 1'b0;
         req_ready <= 1'b1;
         done      <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         lat_din   <= din_n;
         lat_en    <= en_n;
         busy      <= busy_n;
         req_ready <= ready_n;
         done      <= done_n;
      end
   end

   // Next state, counter and output values
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      din_n   = lat_din;
      done_n  = 1'b0;
      case (state)
         S_IDLE: begin
            if (req_valid) begin
               din_n = req_data;
               if (SETUP_CYC != 0) begin
                  state_n = S_SETUP;
                  cnt_n   = SETUP_LD;
               end else begin
                  state_n = S_OPEN;
                  cnt_n   = OPEN_LD;
               end
            end
         end
         S_SETUP: begin
            if (cnt == '0) begin
               state_n = S_OPEN;
               cnt_n   = OPEN_LD;
            end else begin
               cnt_n = cnt - CNT_W'(1);
            end
         end
         S_OPEN: begin
            if (cnt == '0) begin
               if (HOLD_CYC != 0) begin
                  state_n = S_HOLD;
                  cnt_n   = HOLD_LD;
               end else begin
                  state_n = S_IDLE;
                  done_n  = 1'b1;
               end
            end else begin
               cnt_n = cnt - CNT_W'(1);
            end
         end
         S_HOLD: begin
            if (cnt == '0) begin
               state_n = S_IDLE;
               done_n  = 1'b1;
            end else begin
               cnt_n = cnt - CNT_W'(1);
            end
         end
         default: state_n = S_IDLE;
      endcase
      en_n    = (state_n == S_OPEN);
      busy_n  = (state_n != S_IDLE);
      ready_n = (state_n == S_IDLE);
   end

`ifdef LATCH_WRITE_CTRL_READBACK_EN
   logic err_pend, err_pend_n, wr_err_n;

   // Compare on the last OPEN cycle; report together with done
   always_comb begin
      err_pend_n = err_pend;
      wr_err_n   = 1'b0;
      if (state == S_OPEN && cnt == '0) begin
         err_pend_n = (lat_q != lat_din);
         if (HOLD_CYC == 0) wr_err_n = (lat_q != lat_din);
      end
      if (state == S_HOLD && cnt == '0) wr_err_n = err_pend;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_pend <= 1'b0;
         wr_err   <= 1'b0;
      end else begin
         err_pend <= err_pend_n;
         wr_err   <= wr_err_n;
      end
   end
`endif

endmodule

// File: tb/tb_latch_write_ctrl.sv
// Directed self-checking bench for latch_write_ctrl (default params plus a SETUP=0/HOLD=0/OPEN=1 instance).
module tb_latch_write_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_valid, req_valid0;
   logic [7:0] req_data, req_data0;
   logic       req_ready, req_ready0;
   logic [7:0] lat_din, lat_din0;
   logic       lat_en, lat_en0;
   logic       busy, busy0;
   logic       done, done0;
`ifdef LATCH_WRITE_CTRL_READBACK_EN
   logic       flip;
   logic [7:0] lat_q, lat_q0;
   logic       wr_err, wr_err0;
   assign lat_q  = lat_din ^ {7'b0, flip};
   assign lat_q0 = lat_din0;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   latch_write_ctrl u_dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .lat_din(lat_din), .lat_en(lat_en), .busy(busy),
`ifdef LATCH_WRITE_CTRL_READBACK_EN
      .lat_q(lat_q), .wr_err(wr_err),
`endif
      .done(done)
   );

   latch_write_ctrl #(.DATA_W(8), .SETUP_CYC(0), .OPEN_CYC(1), .HOLD_CYC(0)) u_dut0 (
      .clk(clk), .rst(rst), .req_valid(req_valid0), .req_data(req_data0),
      .req_ready(req_ready0), .lat_din(lat_din0), .lat_en(lat_en0), .busy(busy0),
`ifdef LATCH_WRITE_CTRL_READBACK_EN
      .lat_q(lat_q0), .wr_err(wr_err0),
`endif
      .done(done0)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = 1'b0; req_data = 8'h00; req_valid0 = 1'b0; req_data0 = 8'h00;
`ifdef LATCH_WRITE_CTRL_READBACK_EN
      flip = 1'b0;
`endif
      #2;
      checks++;
      if ({lat_en, lat_din, done, busy, req_ready} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL reset: en/din/done/busy/ready got %b %h %b %b %b want 0 00 0 0 1",
                  lat_en, lat_din, done, busy, req_ready);
      end
      checks++;
      if ({lat_en0, lat_din0, done0, busy0, req_ready0} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL reset_p0: en/din/done/busy/ready got %b %h %b %b %b want 0 00 0 0 1",
                  lat_en0, lat_din0, done0, busy0, req_ready0);
      end
      tick(); tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single();
      logic [4:0] en_exp   = 5'b00110;   // bit i = expected value at accept+i
      logic [4:0] done_exp = 5'b10000;
      req_valid = 1'b1; req_data = 8'hA5;
      tick();
      req_valid = 1'b0; req_data = 8'h00;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (lat_en !== en_exp[i] || done !== done_exp[i] || lat_din !== 8'hA5) begin
            errors++;
            $display("FAIL single +%0d: en/done/din got %b %b %h want %b %b a5",
                     i, lat_en, done, lat_din, en_exp[i], done_exp[i]);
         end
         checks++;
         if (busy !== ~done_exp[i] || req_ready !== done_exp[i]) begin
            errors++;
            $display("FAIL single_hs +%0d: busy/ready got %b %b want %b %b",
                     i, busy, req_ready, ~done_exp[i], done_exp[i]);
         end
         if (i < 4) tick();
      end
      tick();
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL single_pulse: done got %b want 0", done);
      end
   endtask

   task automatic test_back_to_back();
      logic [9:0] en_exp   = 10'b0011000110;
      logic [9:0] done_exp = 10'b1000010000;
      req_valid = 1'b1; req_data = 8'hA5;
      tick();
      req_data = 8'h3C;
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (lat_en !== en_exp[i] || done !== done_exp[i] ||
             lat_din !== ((i < 5) ? 8'hA5 : 8'h3C)) begin
            errors++;
            $display("FAIL b2b +%0d: en/done/din got %b %b %h want %b %b %h",
                     i, lat_en, done, lat_din, en_exp[i], done_exp[i], (i < 5) ? 8'hA5 : 8'h3C);
         end
         if (i == 5) req_valid = 1'b0;
         if (i < 9) tick();
      end
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_idle: done/busy got %b %b want 0 0", done, busy);
      end
   endtask

   task automatic test_busy_ignore();
      req_valid = 1'b1; req_data = 8'hA5;
      tick();
      req_valid = 1'b0;
      tick();                               // accept+1, lat_en open
      req_valid = 1'b1; req_data = 8'hFF;
      for (int i = 1; i < 5; i++) begin
         checks++;
         if (lat_din !== 8'hA5 || done !== (i == 4)) begin
            errors++;
            $display("FAIL busy_ign +%0d: din/done got %h %b want a5 %b", i, lat_din, done, i == 4);
         end
         tick();
      end
      checks++;
      if (lat_din !== 8'hFF || busy !== 1'b1 || lat_en !== 1'b0) begin
         errors++;
         $display("FAIL busy_acc: din/busy/en got %h %b %b want ff 1 0", lat_din, busy, lat_en);
      end
      req_valid = 1'b0;
      repeat (5) tick();
   endtask

   task automatic test_reset_mid_open();
      req_valid = 1'b1; req_data = 8'h5A;
      tick();
      req_valid = 1'b0;
      tick();
      checks++;
      if (lat_en !== 1'b1) begin
         errors++;
         $display("FAIL rst_pre: lat_en got %b want 1", lat_en);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (lat_en !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_async: en/done/busy/ready got %b %b %b %b want 0 0 0 1",
                  lat_en, done, busy, req_ready);
      end
      tick();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (done !== 1'b0 || lat_en !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1 ||
             lat_din !== 8'h00) begin
            errors++;
            $display("FAIL rst_idle +%0d: done/en/busy/ready/din got %b %b %b %b %h want 0 0 0 1 00",
                     i, done, lat_en, busy, req_ready, lat_din);
         end
      end
   endtask

   task automatic test_zero_windows();
      req_valid0 = 1'b1; req_data0 = 8'hC3;
      tick();
      req_valid0 = 1'b0;
      checks++;
      if (lat_en0 !== 1'b1 || done0 !== 1'b0 || lat_din0 !== 8'hC3 || busy0 !== 1'b1) begin
         errors++;
         $display("FAIL p0 +0: en/done/din/busy got %b %b %h %b want 1 0 c3 1",
                  lat_en0, done0, lat_din0, busy0);
      end
      tick();
      checks++;
      if (lat_en0 !== 1'b0 || done0 !== 1'b1 || req_ready0 !== 1'b1) begin
         errors++;
         $display("FAIL p0 +1: en/done/ready got %b %b %b want 0 1 1", lat_en0, done0, req_ready0);
      end
      tick();
      checks++;
      if (done0 !== 1'b0 || lat_din0 !== 8'hC3) begin
         errors++;
         $display("FAIL p0 +2: done/din got %b %h want 0 c3", done0, lat_din0);
      end
   endtask

`ifdef LATCH_WRITE_CTRL_READBACK_EN
   task automatic test_readback();
      for (int f = 1; f >= 0; f--) begin
         flip = f[0];
         req_valid = 1'b1; req_data = 8'h96;
         tick();
         req_valid = 1'b0;
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (wr_err !== ((i == 4) && f[0])) begin
               errors++;
               $display("FAIL readback f%0d +%0d: wr_err got %b want %b", f, i, wr_err, (i == 4) && f[0]);
            end
            if (i < 4) tick();
         end
         tick();
      end
      flip = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_busy_ignore();
      test_zero_windows();
`ifdef LATCH_WRITE_CTRL_READBACK_EN
      test_readback();
`endif
      test_reset_mid_open();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
